// File: rtl/wbuf_recv.sv
// wbuf_recv: double-banked weight store between the SRAM-X read port and the MAC array.
// Latency: writes land RD_LAT cycles after WBUF_EN; reads return WOUT one cycle after MAC_EN.
// Backpressure: none on the data path; WBUF_BUSY tells the sequencer to hold while a write or bank swap is outstanding.
//
// Ports:
//   CLK, RSTL                  clock, asynchronous active-low reset
//   WBUF_PURGE                 synchronous clear of valid state, pipe, errors and bank select
//   WBUF_EN/_CTRL/_ALL_EN      write request: slot index, or broadcast to every shadow slot
//   WBUF_SWITCH                swap active/shadow banks once all in-flight writes have landed
//   QX                         SRAM-X read data, valid RD_LAT cycles after WBUF_EN
//   MAC_EN, RIDX               read request into the active bank
//   WOUT, WOUT_VLD             registered read result
//   WBUF_FULL, WBUF_BUSY       shadow bank completely valid / write or swap outstanding
//   WBUF_ERR                   sticky: out-of-range write, or read of an invalid/out-of-range slot
//   WBUF_CNT                   (only with WBUF_CNT_EN defined) count of valid shadow slots
//
// Build option: define WBUF_CNT_EN to add the WBUF_CNT counter port; WBUF_FULL is then derived from it.
module wbuf_recv #(
   parameter int DATA_W = 256,
   parameter int CTRL_W = 6,
   parameter int DEPTH  = 64,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RSTL,
   input  logic              WBUF_PURGE,
   input  logic              WBUF_EN,
   input  logic [CTRL_W-1:0] WBUF_EN_CTRL,
   input  logic              WBUF_ALL_EN,
   input  logic              WBUF_SWITCH,
   input  logic [DATA_W-1:0] QX,
   input  logic              MAC_EN,
   input  logic [CTRL_W-1:0] RIDX,
   output logic [DATA_W-1:0] WOUT,
   output logic              WOUT_VLD,
   output logic              WBUF_FULL,
   output logic              WBUF_BUSY,
   output logic              WBUF_ERR
`ifdef WBUF_CNT_EN
   ,
   output logic [CTRL_W:0]   WBUF_CNT
`endif
);

   localparam logic [CTRL_W:0] DEPTH_N = (CTRL_W+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SWAP} state_t;

   state_t            state;
   logic              bank_sel;

   // write pipe; each entry remembers the bank that was shadow when it was issued
   logic              p_vld  [RD_LAT];
   logic              p_all  [RD_LAT];
   logic              p_bank [RD_LAT];
   logic [CTRL_W-1:0] p_idx  [RD_LAT];

   logic [DEPTH-1:0]  vld_q [2];
   logic [DATA_W-1:0] mem   [2][DEPTH];

   logic              full_q;
   logic              err_q;
   logic              pipe_any;
   logic              pipe_hold;

   // landing stage
   logic              l_vld, l_all, l_bank;
   logic [CTRL_W-1:0] l_idx;
   logic              l_idx_ok, wr_ok, wr_bad;
   logic              rd_ok, rd_bad;

   assign l_vld    = p_vld[RD_LAT-1];
   assign l_all    = p_all[RD_LAT-1];
   assign l_bank   = p_bank[RD_LAT-1];
   assign l_idx    = p_idx[RD_LAT-1];
   assign l_idx_ok = ({1'b0, l_idx} < DEPTH_N);
   assign wr_ok    = l_vld & (l_all | l_idx_ok);
   assign wr_bad   = l_vld & ~l_all & ~l_idx_ok;

   assign rd_ok    = ({1'b0, RIDX} < DEPTH_N) && vld_q[bank_sel][RIDX];
   assign rd_bad   = MAC_EN & ~rd_ok;

   // pipe_hold: something will still be in flight after this edge (the landing
   // stage drains at this edge, a new WBUF_EN refills the pipe).
   always_comb begin
      pipe_any  = 1'b0;
      pipe_hold = WBUF_EN;
      for (int i = 0; i < RD_LAT; i++) begin
         pipe_any = pipe_any | p_vld[i];
         if (i < RD_LAT-1) pipe_hold = pipe_hold | p_vld[i];
      end
   end

   assign WBUF_BUSY = pipe_any | (state != ST_IDLE);
   assign WBUF_FULL = full_q;
   assign WBUF_ERR  = err_q;

   // write pipe
   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         for (int i = 0; i < RD_LAT; i++) begin
            p_vld[i]  <= 1'b0;
            p_all[i]  <= 1'b0;
            p_bank[i] <= 1'b0;
            p_idx[i]  <= '0;
         end
      end else if (WBUF_PURGE) begin
         for (int i = 0; i < RD_LAT; i++) p_vld[i] <= 1'b0;
      end else begin
         p_vld[0]  <= WBUF_EN;
         p_all[0]  <= WBUF_ALL_EN;
         p_bank[0] <= ~bank_sel;
         p_idx[0]  <= WBUF_EN_CTRL;
         for (int i = 1; i < RD_LAT; i++) begin
            p_vld[i]  <= p_vld[i-1];
            p_all[i]  <= p_all[i-1];
            p_bank[i] <= p_bank[i-1];
            p_idx[i]  <= p_idx[i-1];
         end
      end
   end

   // switch FSM: a swap waits until no write remains in flight
   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         state    <= ST_IDLE;
         bank_sel <= 1'b0;
      end else if (WBUF_PURGE) begin
         state    <= ST_IDLE;
         bank_sel <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (WBUF_SWITCH) state <= pipe_hold ? ST_PEND : ST_SWAP;
            ST_PEND: if (!pipe_hold) state <= ST_SWAP;
            ST_SWAP: begin
               state    <= ST_IDLE;
               bank_sel <= ~bank_sel;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // slot data: not reset
   always_ff @(posedge CLK) begin
      if (!WBUF_PURGE && wr_ok) begin
         if (l_all) begin
            for (int i = 0; i < DEPTH; i++) mem[l_bank][i] <= QX;
         end else begin
            mem[l_bank][l_idx] <= QX;
         end
      end
   end

   // valid bitmaps; on swap the old active bank becomes shadow and starts empty
   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         vld_q[0] <= '0;
         vld_q[1] <= '0;
      end else if (WBUF_PURGE) begin
         vld_q[0] <= '0;
         vld_q[1] <= '0;
      end else begin
         if (wr_ok) begin
            if (l_all) vld_q[l_bank] <= '1;
            else       vld_q[l_bank][l_idx] <= 1'b1;
         end
         if (state == ST_SWAP) vld_q[bank_sel] <= '0;
      end
   end

`ifdef WBUF_CNT_EN
   logic [CTRL_W:0] cnt_q;
   assign WBUF_CNT = cnt_q;

   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else if (WBUF_PURGE || state == ST_SWAP) begin
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         // only writes into the current shadow bank count
         if (wr_ok && (l_bank != bank_sel)) begin
            if (l_all)                      cnt_q <= DEPTH_N;
            else if (!vld_q[l_bank][l_idx]) cnt_q <= cnt_q + 1'b1;
         end
         full_q <= (cnt_q == DEPTH_N);
      end
   end
`else
   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         full_q <= 1'b0;
      end else if (WBUF_PURGE || state == ST_SWAP) begin
         full_q <= 1'b0;
      end else begin
         full_q <= &vld_q[~bank_sel];
      end
   end
`endif

   // read port; uses bank_sel as sampled at the request edge, so a read on the
   // swap edge still sees the old active bank
   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         WOUT     <= '0;
         WOUT_VLD <= 1'b0;
      end else if (WBUF_PURGE) begin
         WOUT     <= '0;
         WOUT_VLD <= 1'b0;
      end else if (MAC_EN) begin
         if (rd_ok) begin
            WOUT     <= mem[bank_sel][RIDX];
            WOUT_VLD <= 1'b1;
         end else begin
            WOUT     <= '0;
            WOUT_VLD <= 1'b0;
         end
      end else begin
         WOUT_VLD <= 1'b0;
      end
   end

   // sticky error
   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL)           err_q <= 1'b0;
      else if (WBUF_PURGE) err_q <= 1'b0;
      else if (wr_bad || rd_bad) err_q <= 1'b1;
   end

endmodule

// File: tb/tb_wbuf_recv.sv
// Directed bench for wbuf_recv (DATA_W=256, CTRL_W=6, DEPTH=64, RD_LAT=1).
// Inputs are driven 1 time unit after the rising edge; outputs are checked at that same point.
module tb_wbuf_recv;
   localparam int DATA_W = 256;
   localparam int CTRL_W = 6;

   logic              CLK = 1'b0;
   logic              RSTL;
   logic              WBUF_PURGE, WBUF_EN, WBUF_ALL_EN, WBUF_SWITCH, MAC_EN;
   logic [CTRL_W-1:0] WBUF_EN_CTRL, RIDX;
   logic [DATA_W-1:0] QX, WOUT;
   logic              WOUT_VLD, WBUF_FULL, WBUF_BUSY, WBUF_ERR;
`ifdef WBUF_CNT_EN
   logic [CTRL_W:0]   WBUF_CNT;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [DATA_W-1:0] pat_a5;
   logic [DATA_W-1:0] pat_x;

   wbuf_recv #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(64), .RD_LAT(1)) dut (
      .CLK(CLK), .RSTL(RSTL), .WBUF_PURGE(WBUF_PURGE), .WBUF_EN(WBUF_EN),
      .WBUF_EN_CTRL(WBUF_EN_CTRL), .WBUF_ALL_EN(WBUF_ALL_EN), .WBUF_SWITCH(WBUF_SWITCH),
      .QX(QX), .MAC_EN(MAC_EN), .RIDX(RIDX), .WOUT(WOUT), .WOUT_VLD(WOUT_VLD),
      .WBUF_FULL(WBUF_FULL), .WBUF_BUSY(WBUF_BUSY), .WBUF_ERR(WBUF_ERR)
`ifdef WBUF_CNT_EN
      , .WBUF_CNT(WBUF_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      pat_a5 = {32{8'hA5}};
      pat_x  = 256'h1234_5678;
      RSTL = 1'b0; WBUF_PURGE = 1'b0; WBUF_EN = 1'b0; WBUF_ALL_EN = 1'b0;
      WBUF_SWITCH = 1'b0; MAC_EN = 1'b0; WBUF_EN_CTRL = '0; RIDX = '0; QX = '0;
      #3;
      chk("rst_wout",  WOUT, '0);
      chk("rst_vld",   DATA_W'(WOUT_VLD), '0);
      chk("rst_full",  DATA_W'(WBUF_FULL), '0);
      chk("rst_busy",  DATA_W'(WBUF_BUSY), '0);
      chk("rst_err",   DATA_W'(WBUF_ERR), '0);
      tick(); tick();
      RSTL = 1'b1;
      tick();

      // fill shadow bank 1, QX carries the id of the slot issued one cycle earlier
      for (int k = 0; k < 64; k++) begin
         WBUF_EN = 1'b1; WBUF_EN_CTRL = CTRL_W'(k); QX = DATA_W'(k - 1);
         tick();
      end
      chk("fill_busy_after_last_en", DATA_W'(WBUF_BUSY), 1);
      chk("fill_full_early",         DATA_W'(WBUF_FULL), 0);
      WBUF_EN = 1'b0; QX = DATA_W'(63);
      tick();
      chk("fill_busy_drained",  DATA_W'(WBUF_BUSY), 0);
      chk("fill_full_not_yet",  DATA_W'(WBUF_FULL), 0);
      tick();
      chk("fill_full",          DATA_W'(WBUF_FULL), 1);
`ifdef WBUF_CNT_EN
      chk("fill_cnt",           DATA_W'(WBUF_CNT), 64);
`endif

      // swap with empty pipe goes straight to SWAP
      WBUF_SWITCH = 1'b1;
      tick();
      WBUF_SWITCH = 1'b0;
      chk("swap_busy", DATA_W'(WBUF_BUSY), 1);
      tick();
      chk("swap_done_busy", DATA_W'(WBUF_BUSY), 0);
      chk("swap_full_clr",  DATA_W'(WBUF_FULL), 0);
`ifdef WBUF_CNT_EN
      chk("swap_cnt_clr",   DATA_W'(WBUF_CNT), 0);
`endif
      MAC_EN = 1'b1; RIDX = 6'd5;
      tick();
      chk("rd5_wout", WOUT, DATA_W'(5));
      chk("rd5_vld",  DATA_W'(WOUT_VLD), 1);
      RIDX = 6'd63;
      tick();
      chk("rd63_wout", WOUT, DATA_W'(63));
      MAC_EN = 1'b0;
      tick();
      chk("idle_hold_wout", WOUT, DATA_W'(63));
      chk("idle_vld",       DATA_W'(WOUT_VLD), 0);

      // write slot 3 together with SWITCH: one PEND cycle, then SWAP
      WBUF_EN = 1'b1; WBUF_EN_CTRL = 6'd3; WBUF_SWITCH = 1'b1;
      tick();
      chk("pend_busy", DATA_W'(WBUF_BUSY), 1);
      WBUF_EN = 1'b0; WBUF_SWITCH = 1'b0; QX = pat_x;
      tick();
      chk("pend_swap_busy", DATA_W'(WBUF_BUSY), 1);
      // read issued on the swap edge still sees old active bank 1
      MAC_EN = 1'b1; RIDX = 6'd5;
      tick();
      chk("rd_on_swap_wout", WOUT, DATA_W'(5));
      chk("rd_on_swap_vld",  DATA_W'(WOUT_VLD), 1);
      chk("pend_swap_done",  DATA_W'(WBUF_BUSY), 0);
      RIDX = 6'd3;
      tick();
      chk("rd3_wout", WOUT, pat_x);
      chk("rd3_vld",  DATA_W'(WOUT_VLD), 1);
      chk("rd3_err",  DATA_W'(WBUF_ERR), 0);

      // slot 7 of bank 0 was cleared when bank 0 became shadow
      RIDX = 6'd7;
      tick();
      chk("rd7_wout", WOUT, '0);
      chk("rd7_vld",  DATA_W'(WOUT_VLD), 0);
      chk("rd7_err",  DATA_W'(WBUF_ERR), 1);
      MAC_EN = 1'b0;
      tick(); tick();
      chk("err_sticky", DATA_W'(WBUF_ERR), 1);

      // purge clears error, output and all valid bits
      WBUF_PURGE = 1'b1;
      tick();
      WBUF_PURGE = 1'b0;
      chk("purge_err",  DATA_W'(WBUF_ERR), 0);
      chk("purge_wout", WOUT, '0);
      MAC_EN = 1'b1; RIDX = 6'd3;
      tick();
      MAC_EN = 1'b0;
      chk("purge_rd3_vld", DATA_W'(WOUT_VLD), 0);
      chk("purge_rd3_err", DATA_W'(WBUF_ERR), 1);
      WBUF_PURGE = 1'b1;
      tick();
      WBUF_PURGE = 1'b0;

      // broadcast into shadow bank 1
      WBUF_EN = 1'b1; WBUF_ALL_EN = 1'b1; WBUF_EN_CTRL = 6'd0;
      tick();
      WBUF_EN = 1'b0; WBUF_ALL_EN = 1'b0; QX = pat_a5;
      tick();
      chk("all_full_not_yet", DATA_W'(WBUF_FULL), 0);
      tick();
      chk("all_full", DATA_W'(WBUF_FULL), 1);
`ifdef WBUF_CNT_EN
      chk("all_cnt",  DATA_W'(WBUF_CNT), 64);
`endif
      WBUF_SWITCH = 1'b1;
      tick();
      WBUF_SWITCH = 1'b0;
      tick();
      MAC_EN = 1'b1; RIDX = 6'd0;
      tick();
      chk("all_rd0", WOUT, pat_a5);
      RIDX = 6'd63;
      tick();
      chk("all_rd63", WOUT, pat_a5);
      MAC_EN = 1'b0;

      // reset mid-PEND with a write in flight (target: shadow bank 0)
      QX = pat_x;
      WBUF_EN = 1'b1; WBUF_EN_CTRL = 6'd10; WBUF_SWITCH = 1'b1;
      tick();
      WBUF_EN = 1'b0; WBUF_SWITCH = 1'b0;
      chk("pre_rst_busy", DATA_W'(WBUF_BUSY), 1);
      #2 RSTL = 1'b0;
      #1;
      chk("mid_rst_wout", WOUT, '0);
      chk("mid_rst_busy", DATA_W'(WBUF_BUSY), 0);
      chk("mid_rst_full", DATA_W'(WBUF_FULL), 0);
      tick();
      RSTL = 1'b1;
      tick(); tick();
      chk("post_rst_busy", DATA_W'(WBUF_BUSY), 0);
      MAC_EN = 1'b1; RIDX = 6'd10;
      tick();
      MAC_EN = 1'b0;
      chk("post_rst_rd10_vld", DATA_W'(WOUT_VLD), 0);
      chk("post_rst_rd10_wout", WOUT, '0);
      chk("post_rst_full", DATA_W'(WBUF_FULL), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1);
   end
endmodule
